// File: rtl/fetch_predict.sv
// fetch_predict: fetch-stage PC generation with a direct-mapped BTB and 2-bit
//   counters, plus the F->D pipeline register.
// Latency: lookup is combinational on pcF; F->D register is one cycle.
// Backpressure: stallF holds the PC and stallD holds F->D; redirect overrides both.
// Ports:
//   clk, reset (async, active-low)
//   stallF, stallD, redirect_valid/redirect_pc: pipeline control from later stages
//   upd_valid/upd_pc/upd_taken/upd_target: resolved branch training
//   pcF/instrF: instruction-memory address and returned word
//   instrD, pcD, validD, pred_takenD, pred_targetD: decode-stage outputs
module fetch_predict #(
  parameter int unsigned       XLEN        = 32,
  parameter int unsigned       BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0]   RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pcF,
  input  logic [31:0]     instrF,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic            validD,
  output logic            pred_takenD,
  output logic [XLEN-1:0] pred_targetD
);

  localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDXW - 2;

  // Predictor storage. Only the valid bits are reset; the rest is don't-care
  // until an entry is allocated.
  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAGW-1:0]        btb_tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];
  logic [1:0]             btb_cnt_q    [BTB_ENTRIES];

  logic [XLEN-1:0] pcF_q, pcF_d;
  logic [31:0]     instrD_q;
  logic [XLEN-1:0] pcD_q;
  logic            validD_q;
  logic            pred_takenD_q;
  logic [XLEN-1:0] pred_targetD_q;

  // Lookup on the current fetch address (sees the pre-update entry contents).
  logic [IDXW-1:0] idx_f;
  logic [TAGW-1:0] tag_f;
  logic            hit_f;
  logic            pred_taken_f;
  logic [XLEN-1:0] pred_target_f;

  assign idx_f         = pcF_q[IDXW+1:2];
  assign tag_f         = pcF_q[XLEN-1:IDXW+2];
  assign hit_f         = btb_valid_q[idx_f] && (btb_tag_q[idx_f] == tag_f);
  assign pred_taken_f  = hit_f && btb_cnt_q[idx_f][1];
  assign pred_target_f = btb_target_q[idx_f];

  // Training port decode.
  logic [IDXW-1:0] idx_u;
  logic [TAGW-1:0] tag_u;
  logic            hit_u;

  assign idx_u = upd_pc[IDXW+1:2];
  assign tag_u = upd_pc[XLEN-1:IDXW+2];
  assign hit_u = btb_valid_q[idx_u] && (btb_tag_q[idx_u] == tag_u);

  // Low address bits never participate in indexing; redirect bit 0 is forced to 0.
  logic unused_ok;
  assign unused_ok = ^{redirect_pc[0], upd_pc[1:0]};

  always_comb begin
    pcF_d = pcF_q + XLEN'(4);
    if (redirect_valid) begin
      pcF_d = {redirect_pc[XLEN-1:1], 1'b0};
    end else if (stallF) begin
      pcF_d = pcF_q;
    end else if (pred_taken_f) begin
      pcF_d = pred_target_f;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcF_q          <= RESET_PC;
      instrD_q       <= '0;
      pcD_q          <= '0;
      validD_q       <= 1'b0;
      pred_takenD_q  <= 1'b0;
      pred_targetD_q <= '0;
    end else begin
      pcF_q <= pcF_d;
      if (redirect_valid) begin
        // Flush squashes the single wrong-path instruction; other fields are don't-care.
        validD_q <= 1'b0;
      end else if (!stallD) begin
        instrD_q       <= instrF;
        pcD_q          <= pcF_q;
        validD_q       <= 1'b1;
        pred_takenD_q  <= pred_taken_f;
        pred_targetD_q <= pred_target_f;
      end
    end
  end

  // Valid bits: set on allocation (miss + taken), cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btb_valid_q <= '0;
    end else if (upd_valid && !hit_u && upd_taken) begin
      btb_valid_q[idx_u] <= 1'b1;
    end
  end

  // Unreset payload. Gated by reset so an update coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && upd_valid) begin
      if (hit_u) begin
        if (upd_taken) begin
          btb_target_q[idx_u] <= upd_target;
          if (btb_cnt_q[idx_u] != 2'd3) btb_cnt_q[idx_u] <= btb_cnt_q[idx_u] + 2'd1;
        end else begin
          if (btb_cnt_q[idx_u] != 2'd0) btb_cnt_q[idx_u] <= btb_cnt_q[idx_u] - 2'd1;
        end
      end else if (upd_taken) begin
        btb_tag_q[idx_u]    <= tag_u;
        btb_target_q[idx_u] <= upd_target;
        btb_cnt_q[idx_u]    <= 2'd2;
      end
    end
  end

  assign pcF          = pcF_q;
  assign instrD       = instrD_q;
  assign pcD          = pcD_q;
  assign validD       = validD_q;
  assign pred_takenD  = pred_takenD_q;
  assign pred_targetD = pred_targetD_q;

endmodule

// File: tb/tb_fetch_predict.sv
module tb_fetch_predict;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        pred_takenD;
  logic [31:0] pred_targetD;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory stand-in: each address returns a distinct word.
  assign instrF = ~pcF;

  fetch_predict #(
    .XLEN(32),
    .BTB_ENTRIES(16),
    .RESET_PC(32'h100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stallF(stallF),
    .stallD(stallD),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .pcF(pcF),
    .instrF(instrF),
    .instrD(instrD),
    .pcD(pcD),
    .validD(validD),
    .pred_takenD(pred_takenD),
    .pred_targetD(pred_targetD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    redirect_valid = 1'b0;
    upd_valid      = 1'b0;
    stallF         = 1'b0;
    stallD         = 1'b0;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  initial begin
    reset = 1'b0;
    redirect_pc = '0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    idle();
    #12;
    chk("rst_pcF", pcF, 32'h100);
    chk("rst_validD", {31'd0, validD}, 32'd0);
    chk("rst_instrD", instrD, 32'd0);
    chk("rst_pcD", pcD, 32'd0);
    chk("rst_pred_taken", {31'd0, pred_takenD}, 32'd0);
    chk("rst_pred_target", pred_targetD, 32'd0);

    // Sequential fetch from RESET_PC with an empty predictor.
    step(); reset = 1'b1;
    chk("seq_pc0", pcF, 32'h100);
    step();
    chk("seq_pc1", pcF, 32'h104);
    chk("seq_valid1", {31'd0, validD}, 32'd1);
    chk("seq_pcD1", pcD, 32'h100);
    chk("seq_instrD1", instrD, ~32'h100);
    step();
    chk("seq_pc2", pcF, 32'h108);
    chk("seq_pcD2", pcD, 32'h104);

    // Allocate 0x10 -> 0x40 while redirecting (bit 0 of redirect ignored).
    upd(32'h10, 1'b1, 32'h40); redir(32'h11);
    step(); idle();
    chk("alloc_redir_pc", pcF, 32'h10);
    chk("alloc_redir_flush", {31'd0, validD}, 32'd0);
    step();
    chk("pred_next_pc", pcF, 32'h40);
    chk("pred_takenD", {31'd0, pred_takenD}, 32'd1);
    chk("pred_targetD", pred_targetD, 32'h40);
    chk("pred_pcD", pcD, 32'h10);

    // Counter 2 -> 1 -> 0, then a third not-taken (stays 0).
    upd(32'h10, 1'b0, 32'h0);
    step(); step();
    redir(32'h10);
    step(); idle();
    chk("nt_redir_pc", pcF, 32'h10);
    step();
    chk("nt_next_pc", pcF, 32'h14);
    chk("nt_pred_takenD", {31'd0, pred_takenD}, 32'd0);
    // One taken: 0 -> 1 (still not taken if saturation held).
    redir(32'h10); upd(32'h10, 1'b1, 32'h40);
    step(); idle();
    // Same-cycle lookup/update at 0x10: lookup uses counter 1, update makes it 2 with target 0x80.
    upd(32'h10, 1'b1, 32'h80);
    step(); idle();
    chk("sat0_and_preupd_pc", pcF, 32'h14);
    redir(32'h10);
    step(); idle();
    step();
    chk("retarget_pc", pcF, 32'h80);
    chk("retarget_predD", pred_targetD, 32'h80);

    // Redirect wins over both stalls.
    stallF = 1'b1; stallD = 1'b1; redir(32'h200);
    step(); idle();
    chk("redir_stall_pc", pcF, 32'h200);
    chk("redir_stall_valid", {31'd0, validD}, 32'd0);

    // Three-cycle stall at pcF=0x20 with 0x1C in decode.
    redir(32'h1C);
    step(); idle();
    step();
    chk("stall_pre_pc", pcF, 32'h20);
    stallF = 1'b1; stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pcF", pcF, 32'h20);
      chk("stall_pcD", pcD, 32'h1C);
      chk("stall_instrD", instrD, ~32'h1C);
    end
    idle();
    step();
    chk("unstall_pcF", pcF, 32'h24);
    chk("unstall_pcD", pcD, 32'h20);
    chk("unstall_instrD", instrD, ~32'h20);
    chk("unstall_valid", {31'd0, validD}, 32'd1);

    // PC wraps modulo 2^32.
    redir(32'hFFFF_FFFC);
    step(); idle();
    step();
    chk("wrap_pc", pcF, 32'h0);

    // Alias 0x50 shares index 4 with 0x10 but has a different tag.
    redir(32'h50);
    step(); idle();
    step();
    chk("alias_nohit_pc", pcF, 32'h54);
    chk("alias_nohit_pred", {31'd0, pred_takenD}, 32'd0);
    redir(32'h50); upd(32'h50, 1'b1, 32'h300);
    step(); idle();
    step();
    chk("alias_repl_pc", pcF, 32'h300);
    chk("alias_repl_tgt", pred_targetD, 32'h300);
    redir(32'h10);
    step(); idle();
    step();
    chk("evicted_pc", pcF, 32'h14);
    // Not-taken miss at index 4 must leave the 0x50 entry intact.
    redir(32'h50); upd(32'h90, 1'b0, 32'h500);
    step(); idle();
    step();
    chk("nt_miss_keep_pc", pcF, 32'h300);

    // Reset mid-operation: immediate, and an update held during reset is dropped.
    upd(32'h50, 1'b1, 32'h40);
    reset = 1'b0;
    #1;
    chk("midrst_pcF", pcF, 32'h100);
    chk("midrst_validD", {31'd0, validD}, 32'd0);
    chk("midrst_pcD", pcD, 32'd0);
    step();
    reset = 1'b1; idle();
    chk("postrst_pcF", pcF, 32'h100);
    redir(32'h50);
    step(); idle();
    step();
    chk("postrst_empty_pc", pcF, 32'h54);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_predict.md
FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 Parameter XLEN, 32, datapath and PC width in bits.
REQ-002 Parameter BTB_ENTRIES, 16, number of direct-mapped predictor entries; power of two, 2..256.
REQ-003 Parameter RESET_PC, 32'h0, PC value loaded by reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 stallF  in  1  hold the PC register.
REQ-007 stallD  in  1  hold the F->D register.
REQ-008 redirect_valid  in  1  execute-stage misprediction or jump correction.
REQ-009 redirect_pc  in  XLEN  corrected fetch address; bit 0 is ignored and treated as 0.
REQ-010 upd_valid  in  1  a resolved branch or jump retires to the predictor this cycle.
REQ-011 upd_pc  in  XLEN  PC of the resolved instruction.
REQ-012 upd_taken  in  1  resolved direction.
REQ-013 upd_target  in  XLEN  resolved target.
REQ-014 pcF  out  XLEN  instruction-memory fetch address.
REQ-015 instrF  in  32  instruction word returned combinationally for pcF.
REQ-016 instrD, pcD  out  32, XLEN  decode-stage instruction and its PC.
REQ-017 validD  out  1  instrD holds a real instruction; 0 means bubble.
REQ-018 pred_takenD, pred_targetD  out  1, XLEN  prediction made for instrD; carried to execute for misprediction checking.

Function
REQ-019 Index = pcF[log2(BTB_ENTRIES)+1:2]; tag = pcF[XLEN-1:log2(BTB_ENTRIES)+2]; each entry holds valid, tag, target and a 2-bit saturating counter.
REQ-020 Lookup is combinational: hit = entry valid and tag equal; predict taken = hit and counter >= 2.
REQ-021 Next PC priority: redirect_valid -> redirect_pc; else stallF -> pcF unchanged; else predict taken -> entry target; else pcF+4, modulo 2^XLEN (wraps to 0).
REQ-022 F->D register: redirect_valid -> validD=0, other fields don't-care (flush wins over stallD); else stallD -> hold all fields; else capture instrF, pcF, the prediction and validD=1.
REQ-023 Zero latency: a taken prediction steers the fetch that immediately follows; a redirect steers the fetch on the next cycle and squashes exactly the one wrong-path instruction in F->D.
REQ-024 Update on upd_valid at the clock edge, using upd_pc index and tag.
REQ-025 Update, tag hit: counter +1 if taken (saturate at 3), -1 if not taken (saturate at 0); target overwritten with upd_target when taken.
REQ-026 Update, tag miss, taken: allocate (replace), valid=1, tag, target, counter=2 (weakly taken).
REQ-027 Update, tag miss, not taken: no change.
REQ-028 Lookup and update on the same index in the same cycle: the lookup sees the pre-update entry; the update takes effect next cycle.
REQ-029 Predictor updates proceed during stallF, stallD and redirect cycles.
REQ-030 The block does not decode instructions; a hit is trusted, and a wrong hit is corrected only by redirect.

Reset
REQ-031 While reset=0: pcF=RESET_PC, validD=0, instrD=0, pcD=0, pred_takenD=0, pred_targetD=0, all entry valid bits 0; counters and targets may be left unreset.
REQ-032 Reset deassertion is synchronised by the integrator. The first fetch after release is at RESET_PC with an empty predictor.
REQ-033 Reset asserted mid-operation discards pending updates and in-flight predictions immediately.

Verification
REQ-034 Reset with RESET_PC=32'h100, no stalls, empty BTB -> pcF sequence 100,104,108; validD=1 from the second cycle.
REQ-035 Update pc=0x10, taken, target=0x40, then fetch 0x10 -> next pcF=0x40, pred_takenD=1, pred_targetD=0x40.
REQ-036 Two not-taken updates on the entry from REQ-035 (counter 2->1->0) -> fetch 0x10 is followed by 0x14; a third not-taken update keeps the counter at 0.
REQ-037 redirect_valid=1, pc=0x200 with stallF=stallD=1 in the same cycle -> next pcF=0x200, validD=0.
REQ-038 stallF=stallD=1 for 3 cycles at pcF=0x20 -> pcF, instrD and pcD stay constant and no instruction is lost or duplicated.
REQ-039 XLEN=32, pcF=32'hFFFF_FFFC, no hit -> next pcF=0; an alias at the same index with a different tag -> no hit, then replacement on a taken update.
